fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Parametrised instruction-fetch front end that replaces the bare PC register and fetch mux ahead of the IF/ID buffer. It issues in-order requests to a variable-latency instruction memory over a req/gnt/rvalid handshake and buffers up to DEPTH fetched instructions with their PCs. It presents them to decode over a valid/ready handshake. A redirect (branch, jump, mret, trap) flushes the queue and discards stale in-flight responses.

Parameters:
XLEN, 32, width of PC and addresses
DEPTH, 4, queue entries and the limit on in-flight requests; power of two, at least 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
redirect_valid  in  1  flush the queue and restart fetch at redirect_pc
redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored
imem_req  out  1  fetch request
imem_addr  out  XLEN  fetch address, word aligned
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid; responses return in order
imem_rdata  in  32  instruction word
out_valid  out  1  head entry available to decode
out_pc  out  XLEN  PC of the head entry
out_inst  out  32  instruction of the head entry
out_ready  in  1  decode accepts the head entry

Behaviour:
- State:
  - fetch_pc.
  - Circular buffer of DEPTH entries, each {pc, inst, filled}.
  - Pointers head, alloc, fill, each log2(DEPTH) bits, wrapping mod DEPTH.
  - count, 0..DEPTH.
  - drop_cnt, 0..DEPTH.
- Reset, asynchronous:
  - fetch_pc=RESET_PC; pointers, count and drop_cnt = 0; all entries cleared.
  - imem_req=0, imem_addr=RESET_PC, out_valid=0, out_pc=0, out_inst=0.
- Issue:
  - imem_req = !redirect_valid && (count+drop_cnt < DEPTH).
  - imem_addr = fetch_pc.
  - On req&&gnt: write {fetch_pc, -, filled=0} at alloc; alloc++; count++; fetch_pc += 4, wrapping mod 2^XLEN.
  - imem_addr and imem_req hold stable while req && !gnt.
- Response:
  - On rvalid && drop_cnt>0: discard the response; drop_cnt--.
  - Otherwise on rvalid: inst written at fill, filled=1, fill++.
- Output:
  - out_valid = entry[head].filled && !redirect_valid.
  - out_pc and out_inst come from the head entry.
  - On out_valid && out_ready: head++, count--, and the entry's filled flag is cleared.
  - Minimum latency from rvalid to out_valid is 1 cycle, with no combinational path rvalid to out_valid.
- Redirect, in the cycle redirect_valid=1:
  - No issue and no pop.
  - Next state: head=alloc=fill=0, count=0, all filled=0, fetch_pc={redirect_pc[XLEN-1:2],2'b00}.
  - drop_cnt = (issued-unreturned entries) + drop_cnt − (rvalid ? 1 : 0). Issued-unreturned entries = entries allocated but not filled.
  - A response arriving in the redirect cycle is always discarded.
- Back-to-back redirects: each recomputes drop_cnt; all stale responses are discarded.
- Full: count+drop_cnt == DEPTH gives imem_req=0.
- Simultaneous pop and issue in one cycle: count unchanged.
- Simultaneous pop and fill on the same entry cannot occur, because a pop needs filled=1.
- Illegal conditions, flagged by assertions and not handled:
  - rvalid with no outstanding requests;
  - gnt without req.

Decomposition:
- fetch_pkg: XLEN default, NOP_INST=32'h0000_0013, and typedef fetch_entry_t {pc, inst, filled}.
- Sub-module fetch_buf: circular storage with head/alloc/fill pointers, count, and a flush input.
- fetch_queue holds fetch_pc, drop_cnt, issue gating and redirect logic.

Test Plan:
1. Reset release; gnt=1 constantly; rvalid 1 cycle after gnt with rdata=addr^32'hA5A5_0000; out_ready=1 -> out_pc sequence 0,4,8,12 with matching inst; first out_valid 2 cycles after the first grant.
2. DEPTH=4, out_ready=0 -> exactly 4 grants, then imem_req=0. Then out_ready=1 for one cycle -> one pop (pc 0), and imem_req reasserts the next cycle with addr 0x10.
3. Memory latency 3, two requests in flight, redirect_pc=0x100 -> the two stale responses are not output (drop_cnt 2→0); next out_pc=0x100.
4. Redirect coincident with rvalid and with out_ready=1 on a valid head -> no pop in that cycle; that response is dropped; drop_cnt equals the remaining in-flight count; no stale PC ever appears.
5. redirect_pc=0x102 -> imem_addr=0x100 next cycle. Also: fetch_pc=0xFFFF_FFFC followed by a grant -> next imem_addr=0.
6. Assert rst asynchronously mid-stream, between clock edges -> out_valid=0, imem_req=0, imem_addr=RESET_PC immediately. After release, fetch resumes at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction-fetch queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  // Default PC / address width of the fetch front end
  localparam int XLEN_DEF = 32;

  // Filler instruction held in an entry between issue and fill
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // One queue slot: PC it was fetched from, instruction word, and whether
  // the memory response for it has arrived.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [31:0]         inst;
    logic                filled;
  } fetch_entry_t;

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/fetch_buf.sv
// ============================================================================
//  Module      : fetch_buf
//  Description : Circular fetch buffer with separate allocate / fill / pop
//                pointers. Entries are allocated at issue time (PC known),
//                filled in order as responses return, and popped in order.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_buf
  import fetch_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            push,
  input  logic [XLEN-1:0] push_pc,
  input  logic            fill,
  input  logic [31:0]     fill_inst,
  input  logic            pop,
  output logic [XLEN-1:0] head_pc,
  output logic [31:0]     head_inst,
  output logic            head_filled,
  output logic [CW-1:0]   count,
  output logic [CW-1:0]   pend
);

  fetch_entry_t r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_alloc;
  logic [PW-1:0] r_fill;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_pend;

  // Entry storage: allocate at alloc, fill at fill, retire at head.
  // A push never targets the head of a poppable entry and a fill never
  // targets a freshly allocated slot, so the three writes never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i].filled <= 1'b0;
      end
    end else begin
      if (push) begin
        r_mem[r_alloc].pc     <= XLEN_DEF'(push_pc);
        r_mem[r_alloc].inst   <= NOP_INST;
        r_mem[r_alloc].filled <= 1'b0;
      end
      if (fill) begin
        r_mem[r_fill].inst   <= fill_inst;
        r_mem[r_fill].filled <= 1'b1;
      end
      if (pop) begin
        r_mem[r_head].filled <= 1'b0;
      end
    end
  end

  // Pointers and occupancy counters; DEPTH is a power of two so the
  // pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_alloc <= '0;
      r_fill  <= '0;
      r_count <= '0;
      r_pend  <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_alloc <= '0;
      r_fill  <= '0;
      r_count <= '0;
      r_pend  <= '0;
    end else begin
      if (push) r_alloc <= r_alloc + PW'(1);
      if (fill) r_fill  <= r_fill + PW'(1);
      if (pop)  r_head  <= r_head + PW'(1);
      r_count <= r_count + CW'(push) - CW'(pop);
      r_pend  <= r_pend + CW'(push) - CW'(fill);
    end
  end

  assign head_pc     = XLEN'(r_mem[r_head].pc);
  assign head_inst   = r_mem[r_head].inst;
  assign head_filled = r_mem[r_head].filled;
  assign count       = r_count;
  assign pend        = r_pend;

endmodule : fetch_buf

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction-fetch front end. Issues in-order requests over a
//                req/gnt/rvalid handshake, buffers up to DEPTH instructions
//                with their PCs and hands them to decode over valid/ready.
//                A redirect flushes the buffer and arranges for every stale
//                in-flight response to be discarded on return.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int               XLEN     = XLEN_DEF,
  parameter  int               DEPTH    = 4,
  parameter  logic [XLEN-1:0]  RESET_PC = '0,
  localparam int               CW       = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  input  logic            out_ready
);

  localparam logic [CW:0] c_depth = (CW+1)'(DEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_drop_cnt;

  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_pend;
  logic [CW:0]     w_occupancy;
  logic            w_issue;
  logic            w_drop;
  logic            w_fill;
  logic            w_pop;
  logic            w_head_filled;
  logic [XLEN-1:0] w_head_pc;
  logic [31:0]     w_head_inst;
  logic [CW-1:0]   w_redirect_drop;
  logic            w_unused_pc_lsbs;

  // Live entries plus stale responses still owed by memory bound the
  // number of requests we may have outstanding.
  assign w_occupancy = {1'b0, w_count} + {1'b0, r_drop_cnt};

  // Request is gated by reset so the port goes quiet the instant reset
  // is asserted, not at the next edge.
  assign imem_req  = !rst && !redirect_valid && (w_occupancy < c_depth);
  assign imem_addr = r_fetch_pc;

  assign w_issue = imem_req && imem_gnt;
  assign w_drop  = imem_rvalid && (r_drop_cnt != '0);
  // A response landing in a redirect cycle is stale by definition.
  assign w_fill  = imem_rvalid && !w_drop && !redirect_valid;

  assign out_valid = w_head_filled && !redirect_valid;
  assign out_pc    = w_head_pc;
  assign out_inst  = w_head_inst;
  assign w_pop     = out_valid && out_ready;

  // Everything issued but not yet returned becomes stale on redirect, on
  // top of what was already owed; the response arriving right now (if
  // any) is consumed this cycle and so is taken off the total.
  assign w_redirect_drop = w_pend + r_drop_cnt - CW'(imem_rvalid);

  assign w_unused_pc_lsbs = ^redirect_pc[1:0];

  fetch_buf #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .flush       (redirect_valid),
    .push        (w_issue),
    .push_pc     (r_fetch_pc),
    .fill        (w_fill),
    .fill_inst   (imem_rdata),
    .pop         (w_pop),
    .head_pc     (w_head_pc),
    .head_inst   (w_head_inst),
    .head_filled (w_head_filled),
    .count       (w_count),
    .pend        (w_pend)
  );

  // Fetch PC: restart word-aligned on redirect, advance one word per grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
    end else if (w_issue) begin
      r_fetch_pc <= r_fetch_pc + XLEN'(4);
    end
  end

  // Stale-response counter: reloaded on every redirect, drained by returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (redirect_valid) begin
      r_drop_cnt <= w_redirect_drop;
    end else if (w_drop) begin
      r_drop_cnt <= r_drop_cnt - CW'(1);
    end
  end

`ifndef SYNTHESIS
  // Memory must only grant a request that is being made.
  a_gnt_needs_req : assert property (@(posedge clk) disable iff (rst)
    imem_gnt |-> imem_req);

  // Memory must not return more responses than were requested.
  a_rvalid_needs_outstanding : assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> ((w_pend + r_drop_cnt) != '0));
`endif

endmodule : fetch_queue

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Self-checking bench for fetch_queue with a behavioural
//                memory and a queue-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready = 1'b0;
  logic        gnt_en = 1'b0;

  // Memory only ever grants a live request.
  assign imem_gnt = gnt_en & imem_req;

  always #5 clk = ~clk;

  fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_ready      (out_ready)
  );

  // Memory: in-order outstanding requests tagged with the epoch they were issued in
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  // Reference: PCs issued in the current epoch and not yet consumed
  typedef struct {
    logic [31:0] pc;
    bit          ret;
  } ment_t;
  ment_t m_q[$];

  logic [31:0] m_fetch_pc = RESET_PC;
  int          epoch = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          rv_en = 1'b1;
  int          tests = 0;
  int          fails = 0;
  int          grants = 0;
  int          first_valid_cyc = -1;
  logic [31:0] pops_log[$];

  bit          s_req;
  logic [31:0] s_addr;
  bit          s_valid;
  logic [31:0] s_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int stale_cnt();
    int n = 0;
    foreach (mq[i]) if (mq[i].epoch != epoch) n++;
    return n;
  endfunction

  function automatic int due_for_new();
    int d = cyc + lat;
    if (mq.size() > 0 && mq[mq.size()-1].due > d) d = mq[mq.size()-1].due;
    return d;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy);
    bit    exp_req;
    bit    exp_valid;
    bit    rv;
    bit    found;
    mreq_t r;
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = rdy;
    rv = (mq.size() > 0) && (mq[0].due <= cyc) && rv_en;
    imem_rvalid = rv;
    imem_rdata  = rv ? (mq[0].addr ^ 32'hA5A5_0000) : $urandom;
    #1;
    exp_req = !redir && ((m_q.size() + stale_cnt()) < DEPTH);
    chk("imem_req", {63'd0, imem_req}, {63'd0, exp_req});
    if (exp_req) chk("imem_addr", {32'd0, imem_addr}, {32'd0, m_fetch_pc});
    exp_valid = !redir && (m_q.size() > 0) && m_q[0].ret;
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
    if (exp_valid) begin
      chk("out_pc", {32'd0, out_pc}, {32'd0, m_q[0].pc});
      chk("out_inst", {32'd0, out_inst}, {32'd0, m_q[0].pc ^ 32'hA5A5_0000});
    end
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = out_valid;
    s_pc    = out_pc;
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    @(posedge clk);
    if (rv) begin
      r = mq.pop_front();
      if (r.epoch == epoch && !redir) begin
        found = 1'b0;
        for (int i = 0; i < m_q.size(); i++) begin
          if (!found && !m_q[i].ret) begin
            m_q[i].ret = 1'b1;
            found = 1'b1;
          end
        end
      end
    end
    if (exp_req && gnt_en) begin
      mq.push_back('{addr: m_fetch_pc, epoch: epoch, due: due_for_new()});
      m_q.push_back('{pc: m_fetch_pc, ret: 1'b0});
      m_fetch_pc = m_fetch_pc + 32'd4;
      grants++;
    end
    if (exp_valid && rdy) begin
      pops_log.push_back(m_q[0].pc);
      void'(m_q.pop_front());
    end
    if (redir) begin
      epoch++;
      m_q.delete();
      m_fetch_pc = {rpc[31:2], 2'b00};
    end
    cyc++;
    @(negedge clk);
  endtask

  // Asynchronous reset applied between clock edges; outputs must react at once.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    redirect_valid = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    chk("rst_imem_req", {63'd0, imem_req}, 64'd0);
    chk("rst_imem_addr", {32'd0, imem_addr}, {32'd0, RESET_PC});
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_pc", {32'd0, out_pc}, 64'd0);
    chk("rst_out_inst", {32'd0, out_inst}, 64'd0);
    mq.delete();
    m_q.delete();
    m_fetch_pc = RESET_PC;
    epoch++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int base;
    // Test 1: streaming with 1-cycle memory and decode always ready
    do_reset();
    lat = 1; rv_en = 1'b1; gnt_en = 1'b1;
    base = cyc; first_valid_cyc = -1; pops_log.delete();
    repeat (12) step(1'b0, 32'd0, 1'b1);
    chk("t1_first_valid_lat", 64'(first_valid_cyc - base), 64'd2);
    chk("t1_pop_count_ge4", {63'd0, pops_log.size() >= 4}, 64'd1);
    for (int i = 0; i < 4 && i < pops_log.size(); i++)
      chk("t1_pc_seq", {32'd0, pops_log[i]}, 64'(i * 4));

    // Test 2: decode stalled -> exactly DEPTH grants, then a single pop reopens issue
    do_reset();
    grants = 0;
    repeat (8) step(1'b0, 32'd0, 1'b0);
    chk("t2_grants", 64'(grants), 64'(DEPTH));
    chk("t2_req_full", {63'd0, s_req}, 64'd0);
    step(1'b0, 32'd0, 1'b1);
    chk("t2_pop_valid", {63'd0, s_valid}, 64'd1);
    chk("t2_pop_pc", {32'd0, s_pc}, 64'd0);
    step(1'b0, 32'd0, 1'b0);
    chk("t2_req_again", {63'd0, s_req}, 64'd1);
    chk("t2_addr_again", {32'd0, s_addr}, 64'h10);

    // Test 3: redirect with two requests in flight on a 3-cycle memory
    do_reset();
    lat = 3;
    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    step(1'b1, 32'h100, 1'b1);
    pops_log.delete();
    repeat (14) step(1'b0, 32'd0, 1'b1);
    chk("t3_first_after_redirect", {32'd0, pops_log.size() > 0 ? pops_log[0] : 32'hDEAD_BEEF}, 64'h100);

    // Test 4: redirect coincident with a response and a ready, valid head
    do_reset();
    lat = 2;
    repeat (3) step(1'b0, 32'd0, 1'b1);
    step(1'b1, 32'h200, 1'b1);
    chk("t4_no_pop_on_redirect", {63'd0, s_valid}, 64'd0);
    pops_log.delete();
    repeat (14) step(1'b0, 32'd0, 1'b1);
    chk("t4_first_after_redirect", {32'd0, pops_log.size() > 0 ? pops_log[0] : 32'hDEAD_BEEF}, 64'h200);

    // Test 5: unaligned redirect target and PC wrap-around
    lat = 1;
    step(1'b1, 32'h102, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    chk("t5_aligned_addr", {32'd0, s_addr}, 64'h100);
    step(1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    chk("t5_top_addr", {32'd0, s_addr}, 64'hFFFF_FFFC);
    chk("t5_top_req", {63'd0, s_req}, 64'd1);
    step(1'b0, 32'd0, 1'b1);
    chk("t5_wrap_addr", {32'd0, s_addr}, 64'h0);
    repeat (6) step(1'b0, 32'd0, 1'b1);

    // Test 6 plus randomized traffic: mid-stream async resets, random
    // latency, grant/response gaps, backpressure and redirects.
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 75) do_reset();
      if (i % 10 == 0) lat = $urandom_range(1, 4);
      gnt_en = ($urandom % 4) != 0;
      rv_en  = ($urandom % 4) != 0;
      step(($urandom % 20) == 0, $urandom, ($urandom % 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_fetch_queue

`default_nettype wire
